// File: rtl/caf_controller.sv
// CAF engine controller: loads frequency steps into the slices, gates the sample stream,
// then scans the slice peaks and returns the global maximum.
module caf_controller #(
  parameter int unsigned phase_bits          = 10,
  parameter int unsigned foas                = 3,
  parameter int unsigned foas_counter_bits   = 2,
  parameter int unsigned length_counter_bits = 3,
  parameter int unsigned out_max_bits        = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  // frequency step load
  input  logic                                s_axis_freq_step_tvalid,
  input  logic [phase_bits-1:0]               freq_step,
  input  logic                                neg_shift,
  output logic                                s_axis_freq_step_tready,
  output logic [phase_bits-1:0]               slice_freq_step,
  output logic [foas-1:0]                     slice_freq_step_valid,
  output logic [foas-1:0]                     slice_neg_shift,
  // sample stream gating
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic                                slice_sample_tvalid,
  input  logic [foas-1:0]                     slice_tready,
  // slice results
  input  logic [foas-1:0]                     slice_result_tvalid,
  input  logic [foas*out_max_bits-1:0]        slice_out_max,
  input  logic [foas*length_counter_bits-1:0] slice_index,
  output logic [foas-1:0]                     slice_result_tready,
  // global result
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [out_max_bits-1:0]             out_max,
  output logic [length_counter_bits-1:0]      index,
  output logic [foas_counter_bits-1:0]        freq_step_index,
  output logic                                busy
);

  typedef enum logic [1:0] {
    StLoad,
    StCorrelate,
    StFindMax,
    StReturnMax
  } state_e;

  localparam logic [foas_counter_bits-1:0] LastSlice = foas_counter_bits'(foas - 1);

  state_e                         state_q;
  logic [foas_counter_bits-1:0]   load_cnt_q;
  logic [foas_counter_bits-1:0]   scan_q;
  logic [foas-1:0]                load_onehot;
  logic [out_max_bits-1:0]        cur_max;
  logic [length_counter_bits-1:0] cur_idx;

  // Decode the load counter into the slice strobe and select the slice under scan.
  always_comb begin
    load_onehot = '0;
    cur_max     = '0;
    cur_idx     = '0;
    for (int k = 0; k < foas; k++) begin
      if (load_cnt_q == foas_counter_bits'(k)) begin
        load_onehot[k] = 1'b1;
      end
      if (scan_q == foas_counter_bits'(k)) begin
        cur_max = slice_out_max[k*out_max_bits +: out_max_bits];
        cur_idx = slice_index[k*length_counter_bits +: length_counter_bits];
      end
    end
  end

  // Handshake readies are combinational but forced low while reset is held.
  assign s_axis_freq_step_tready = !rst && (state_q == StLoad);
  assign s_axis_tready           = !rst && (state_q == StCorrelate) && (&slice_tready);
  assign slice_sample_tvalid     = s_axis_tvalid && s_axis_tready;
  assign slice_result_tready     = {foas{!rst && (state_q == StReturnMax) && m_axis_tready}};
  assign busy                    = !rst && (state_q != StLoad);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= StLoad;
      load_cnt_q            <= '0;
      scan_q                <= '0;
      slice_freq_step       <= '0;
      slice_freq_step_valid <= '0;
      slice_neg_shift       <= '0;
      m_axis_tvalid         <= 1'b0;
      out_max               <= '0;
      index                 <= '0;
      freq_step_index       <= '0;
    end else begin
      slice_freq_step_valid <= '0;
      slice_neg_shift       <= '0;
      unique case (state_q)
        StLoad: begin
          if (s_axis_freq_step_tvalid) begin
            slice_freq_step       <= freq_step;
            slice_freq_step_valid <= load_onehot;
            slice_neg_shift       <= neg_shift ? load_onehot : '0;
            if (load_cnt_q == LastSlice) begin
              load_cnt_q <= '0;
              state_q    <= StCorrelate;
            end else begin
              load_cnt_q <= load_cnt_q + 1'b1;
            end
          end
        end
        StCorrelate: begin
          if (&slice_result_tvalid) begin
            scan_q  <= '0;
            state_q <= StFindMax;
          end
        end
        StFindMax: begin
          // Strict compare keeps the lowest slice index on ties.
          if ((scan_q == '0) || (cur_max > out_max)) begin
            out_max         <= cur_max;
            index           <= cur_idx;
            freq_step_index <= scan_q;
          end
          if (scan_q == LastSlice) begin
            m_axis_tvalid <= 1'b1;
            state_q       <= StReturnMax;
          end else begin
            scan_q <= scan_q + 1'b1;
          end
        end
        StReturnMax: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            state_q       <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_caf_controller.sv
// Self-checking bench for caf_controller: directed scenarios plus randomized peak scans
// against a max-then-first-occurrence reference model; a second foas=1 instance is also checked.
module tb_caf_controller;

  logic        clk = 1'b0;
  logic        rst;
  // foas = 3 instance
  logic        fs_tvalid;
  logic [9:0]  freq_step;
  logic        neg_shift;
  logic        fs_tready;
  logic [9:0]  slice_freq_step;
  logic [2:0]  sfs_valid;
  logic [2:0]  slice_neg_shift;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        slice_sample_tvalid;
  logic [2:0]  slice_tready;
  logic [2:0]  slice_result_tvalid;
  logic [191:0] slice_out_max;
  logic [8:0]  slice_index;
  logic [2:0]  slice_result_tready;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] out_max;
  logic [2:0]  index;
  logic [1:0]  freq_step_index;
  logic        busy;
  // foas = 1 instance
  logic        fs_tvalid_1;
  logic [9:0]  freq_step_1;
  logic        neg_shift_1;
  logic        fs_tready_1;
  logic [9:0]  slice_freq_step_1;
  logic        sfs_valid_1;
  logic        slice_neg_shift_1;
  logic        s_axis_tvalid_1;
  logic        s_axis_tready_1;
  logic        slice_sample_tvalid_1;
  logic        slice_tready_1;
  logic        slice_result_tvalid_1;
  logic [63:0] slice_out_max_1;
  logic [2:0]  slice_index_1;
  logic        slice_result_tready_1;
  logic        m_axis_tvalid_1;
  logic        m_axis_tready_1;
  logic [63:0] out_max_1;
  logic [2:0]  index_1;
  logic        freq_step_index_1;
  logic        busy_1;

  int checks = 0;
  int errors = 0;

  logic [9:0]  st [3];
  logic        ng [3];
  logic [63:0] pk [3];
  logic [2:0]  ix [3];

  caf_controller dut (
    .clk(clk), .rst(rst),
    .s_axis_freq_step_tvalid(fs_tvalid), .freq_step(freq_step), .neg_shift(neg_shift),
    .s_axis_freq_step_tready(fs_tready), .slice_freq_step(slice_freq_step),
    .slice_freq_step_valid(sfs_valid), .slice_neg_shift(slice_neg_shift),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .slice_sample_tvalid(slice_sample_tvalid), .slice_tready(slice_tready),
    .slice_result_tvalid(slice_result_tvalid), .slice_out_max(slice_out_max),
    .slice_index(slice_index), .slice_result_tready(slice_result_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .out_max(out_max),
    .index(index), .freq_step_index(freq_step_index), .busy(busy)
  );

  caf_controller #(
    .phase_bits(10), .foas(1), .foas_counter_bits(1), .length_counter_bits(3),
    .out_max_bits(64)
  ) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_freq_step_tvalid(fs_tvalid_1), .freq_step(freq_step_1), .neg_shift(neg_shift_1),
    .s_axis_freq_step_tready(fs_tready_1), .slice_freq_step(slice_freq_step_1),
    .slice_freq_step_valid(sfs_valid_1), .slice_neg_shift(slice_neg_shift_1),
    .s_axis_tvalid(s_axis_tvalid_1), .s_axis_tready(s_axis_tready_1),
    .slice_sample_tvalid(slice_sample_tvalid_1), .slice_tready(slice_tready_1),
    .slice_result_tvalid(slice_result_tvalid_1), .slice_out_max(slice_out_max_1),
    .slice_index(slice_index_1), .slice_result_tready(slice_result_tready_1),
    .m_axis_tvalid(m_axis_tvalid_1), .m_axis_tready(m_axis_tready_1), .out_max(out_max_1),
    .index(index_1), .freq_step_index(freq_step_index_1), .busy(busy_1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    tick();
    tick();
    checks++; if (fs_tready !== 1'b0) $display("FAIL rst_fs_tready: got %0h want 0", fs_tready);
    else checks += 0;
    if (fs_tready !== 1'b0) errors++;
    checks++; if (s_axis_tready !== 1'b0 || slice_sample_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_sample: got %0h/%0h want 0/0", s_axis_tready, slice_sample_tvalid);
    end
    checks++; if (slice_result_tready !== 3'b000) begin
      errors++; $display("FAIL rst_result_tready: got %0h want 0", slice_result_tready);
    end
    checks++; if (sfs_valid !== 3'b000 || slice_neg_shift !== 3'b000 || slice_freq_step !== 10'd0) begin
      errors++; $display("FAIL rst_strobes: got %0h/%0h/%0h want 0", sfs_valid, slice_neg_shift, slice_freq_step);
    end
    checks++; if (m_axis_tvalid !== 1'b0 || out_max !== 64'd0 || index !== 3'd0 ||
                  freq_step_index !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_result: got v%0h m%0h i%0h f%0h b%0h want all 0",
                         m_axis_tvalid, out_max, index, freq_step_index, busy);
    end
    checks++; if (fs_tready_1 !== 1'b0 || m_axis_tvalid_1 !== 1'b0 || out_max_1 !== 64'd0) begin
      errors++; $display("FAIL rst_foas1: got %0h/%0h/%0h want 0", fs_tready_1, m_axis_tvalid_1, out_max_1);
    end
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (fs_tready !== 1'b1) begin
      errors++; $display("FAIL rst_release_fs_tready: got %0h want 1", fs_tready);
    end
  endtask

  // Offers st[]/ng[] back-to-back and checks each strobe lands on the next slice in turn.
  task automatic load_steps();
    logic [2:0] e;
    for (int i = 0; i < 3; i++) begin
      fs_tvalid = 1'b1;
      freq_step = st[i];
      neg_shift = ng[i];
      #1;
      checks++; if (fs_tready !== 1'b1) begin
        errors++; $display("FAIL load_tready[%0d]: got %0h want 1", i, fs_tready);
      end
      tick();
      e = '0;
      e[i] = 1'b1;
      checks++; if (sfs_valid !== e || slice_freq_step !== st[i]) begin
        errors++; $display("FAIL load_strobe[%0d]: got %0h/%0h want %0h/%0h",
                           i, sfs_valid, slice_freq_step, e, st[i]);
      end
      checks++; if (slice_neg_shift !== (ng[i] ? e : 3'b000)) begin
        errors++; $display("FAIL load_neg[%0d]: got %0h want %0h", i, slice_neg_shift,
                           ng[i] ? e : 3'b000);
      end
    end
    fs_tvalid = 1'b0;
    neg_shift = 1'b0;
    checks++; if (busy !== 1'b1 || fs_tready !== 1'b0) begin
      errors++; $display("FAIL load_enter_corr: got busy %0h tready %0h want 1/0", busy, fs_tready);
    end
  endtask

  task automatic random_steps();
    for (int i = 0; i < 3; i++) begin
      st[i] = 10'($urandom);
      ng[i] = 1'($urandom);
    end
  endtask

  // Presents pk[]/ix[] as slice results and checks latency, value, stall hold and release.
  task automatic run_result(input int stall);
    logic [63:0] em;
    logic [2:0]  ei;
    logic [1:0]  ef;
    int cnt;
    em = pk[0];
    for (int k = 1; k < 3; k++) if (pk[k] > em) em = pk[k];
    ef = 2'd0;
    for (int k = 2; k >= 0; k--) if (pk[k] == em) ef = 2'(k);
    ei = ix[ef];
    for (int k = 0; k < 3; k++) begin
      slice_out_max[k*64 +: 64] = pk[k];
      slice_index[k*3 +: 3] = ix[k];
    end
    slice_result_tvalid = 3'b111;
    tick();
    cnt = 0;
    while (m_axis_tvalid !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++; if (cnt != 3) begin
      errors++; $display("FAIL result_latency: got %0d cycles want 3", cnt);
    end
    checks++; if (out_max !== em || index !== ei || freq_step_index !== ef) begin
      errors++; $display("FAIL result_value: got %0h/%0h/%0h want %0h/%0h/%0h",
                         out_max, index, freq_step_index, em, ei, ef);
    end
    m_axis_tready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      checks++; if (m_axis_tvalid !== 1'b1 || out_max !== em || index !== ei ||
                    freq_step_index !== ef || slice_result_tready !== 3'b000) begin
        errors++; $display("FAIL stall_hold[%0d]: got v%0h m%0h i%0h f%0h r%0h want 1/%0h/%0h/%0h/0",
                           s, m_axis_tvalid, out_max, index, freq_step_index,
                           slice_result_tready, em, ei, ef);
      end
    end
    m_axis_tready = 1'b1;
    #1;
    checks++; if (slice_result_tready !== 3'b111) begin
      errors++; $display("FAIL release_pulse: got %0h want 7", slice_result_tready);
    end
    tick();
    m_axis_tready = 1'b0;
    slice_result_tvalid = 3'b000;
    #1;
    checks++; if (slice_result_tready !== 3'b000 || m_axis_tvalid !== 1'b0 ||
                  fs_tready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL back_to_load: got r%0h v%0h t%0h b%0h want 0/0/1/0",
                         slice_result_tready, m_axis_tvalid, fs_tready, busy);
    end
  endtask

  task automatic test_peaks();
    st = '{10'h010, 10'h020, 10'h030};
    ng = '{1'b0, 1'b1, 1'b0};
    load_steps();
    tick();
    checks++; if (sfs_valid !== 3'b000) begin
      errors++; $display("FAIL strobe_one_cycle: got %0h want 0", sfs_valid);
    end
    pk = '{64'd5, 64'd9, 64'd7};
    ix = '{3'd1, 3'd4, 3'd2};
    run_result(0);
    checks++; if (out_max !== 64'd9 || index !== 3'd4 || freq_step_index !== 2'd1) begin
      errors++; $display("FAIL peak_directed: got %0h/%0h/%0h want 9/4/1",
                         out_max, index, freq_step_index);
    end
    load_steps();
    pk = '{64'd8, 64'd8, 64'd3};
    ix = '{3'd6, 3'd5, 3'd0};
    run_result(1);
    load_steps();
    pk = '{64'd0, 64'd0, 64'd0};
    ix = '{3'd3, 3'd7, 3'd1};
    run_result(0);
  endtask

  task automatic test_back_to_back_stall();
    random_steps();
    load_steps();
    pk = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    ix = '{3'd2, 3'd3, 3'd5};
    run_result(10);
  endtask

  task automatic test_correlate_gating();
    random_steps();
    load_steps();
    s_axis_tvalid = 1'b1;
    slice_tready = 3'b110;
    #1;
    checks++; if (s_axis_tready !== 1'b0 || slice_sample_tvalid !== 1'b0) begin
      errors++; $display("FAIL gate_not_ready: got %0h/%0h want 0/0", s_axis_tready, slice_sample_tvalid);
    end
    slice_tready = 3'b111;
    #1;
    checks++; if (s_axis_tready !== 1'b1 || slice_sample_tvalid !== 1'b1) begin
      errors++; $display("FAIL gate_ready: got %0h/%0h want 1/1", s_axis_tready, slice_sample_tvalid);
    end
    s_axis_tvalid = 1'b0;
    #1;
    checks++; if (slice_sample_tvalid !== 1'b0) begin
      errors++; $display("FAIL gate_no_valid: got %0h want 0", slice_sample_tvalid);
    end
    fs_tvalid = 1'b1;
    freq_step = 10'h3FF;
    #1;
    checks++; if (fs_tready !== 1'b0) begin
      errors++; $display("FAIL step_in_corr_tready: got %0h want 0", fs_tready);
    end
    tick();
    tick();
    fs_tvalid = 1'b0;
    checks++; if (sfs_valid !== 3'b000 || busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL step_in_corr_ignored: got s%0h b%0h v%0h want 0/1/0",
                         sfs_valid, busy, m_axis_tvalid);
    end
    pk = '{64'd1, 64'd2, 64'd3};
    ix = '{3'd0, 3'd1, 3'd2};
    run_result(0);
  endtask

  task automatic test_reset_mid();
    random_steps();
    load_steps();
    pk = '{64'd4, 64'd40, 64'd2};
    ix = '{3'd1, 3'd6, 3'd3};
    for (int k = 0; k < 3; k++) begin
      slice_out_max[k*64 +: 64] = pk[k];
      slice_index[k*3 +: 3] = ix[k];
    end
    slice_result_tvalid = 3'b111;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (sfs_valid !== 3'b000 || m_axis_tvalid !== 1'b0 || out_max !== 64'd0 ||
                  index !== 3'd0 || freq_step_index !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_findmax: got s%0h v%0h m%0h i%0h f%0h b%0h want all 0",
                         sfs_valid, m_axis_tvalid, out_max, index, freq_step_index, busy);
    end
    rst = 1'b0;
    slice_result_tvalid = 3'b000;
    tick();
    tick();
    checks++; if (fs_tready !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_findmax_load: got t%0h b%0h v%0h want 1/0/0",
                         fs_tready, busy, m_axis_tvalid);
    end
    // Mid-LOAD reset: one step accepted, then reset must restart the slice counter.
    fs_tvalid = 1'b1;
    freq_step = 10'h155;
    tick();
    fs_tvalid = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (sfs_valid !== 3'b000 || slice_freq_step !== 10'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_load: got s%0h f%0h b%0h want 0/0/0", sfs_valid, slice_freq_step, busy);
    end
    rst = 1'b0;
    random_steps();
    load_steps();
    pk = '{64'd7, 64'd7, 64'd7};
    ix = '{3'd4, 3'd1, 3'd2};
    run_result(2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      random_steps();
      load_steps();
      for (int k = 0; k < 3; k++) begin
        pk[k] = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
        ix[k] = 3'($urandom);
      end
      run_result(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_foas1();
    int cnt;
    logic [63:0] m;
    logic [2:0]  i;
    logic [9:0]  s;
    for (int n = 0; n < 3; n++) begin
      s = 10'($urandom);
      m = {$urandom, $urandom};
      i = 3'($urandom);
      fs_tvalid_1 = 1'b1;
      freq_step_1 = s;
      neg_shift_1 = 1'b1;
      #1;
      checks++; if (fs_tready_1 !== 1'b1) begin
        errors++; $display("FAIL f1_tready: got %0h want 1", fs_tready_1);
      end
      tick();
      fs_tvalid_1 = 1'b0;
      neg_shift_1 = 1'b0;
      checks++; if (sfs_valid_1 !== 1'b1 || slice_neg_shift_1 !== 1'b1 ||
                    slice_freq_step_1 !== s || busy_1 !== 1'b1) begin
        errors++; $display("FAIL f1_load: got %0h/%0h/%0h/%0h want 1/1/%0h/1",
                           sfs_valid_1, slice_neg_shift_1, slice_freq_step_1, busy_1, s);
      end
      slice_out_max_1 = m;
      slice_index_1 = i;
      slice_result_tvalid_1 = 1'b1;
      tick();
      cnt = 0;
      while (m_axis_tvalid_1 !== 1'b1 && cnt < 20) begin
        tick();
        cnt++;
      end
      checks++; if (cnt != 1 || out_max_1 !== m || index_1 !== i || freq_step_index_1 !== 1'b0) begin
        errors++; $display("FAIL f1_result: got lat %0d %0h/%0h/%0h want 1 %0h/%0h/0",
                           cnt, out_max_1, index_1, freq_step_index_1, m, i);
      end
      m_axis_tready_1 = 1'b1;
      #1;
      checks++; if (slice_result_tready_1 !== 1'b1) begin
        errors++; $display("FAIL f1_release: got %0h want 1", slice_result_tready_1);
      end
      tick();
      m_axis_tready_1 = 1'b0;
      slice_result_tvalid_1 = 1'b0;
      #1;
      checks++; if (fs_tready_1 !== 1'b1 || m_axis_tvalid_1 !== 1'b0) begin
        errors++; $display("FAIL f1_back_to_load: got %0h/%0h want 1/0", fs_tready_1, m_axis_tvalid_1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    fs_tvalid = 1'b0; freq_step = '0; neg_shift = 1'b0;
    s_axis_tvalid = 1'b0; slice_tready = 3'b111;
    slice_result_tvalid = '0; slice_out_max = '0; slice_index = '0; m_axis_tready = 1'b0;
    fs_tvalid_1 = 1'b0; freq_step_1 = '0; neg_shift_1 = 1'b0;
    s_axis_tvalid_1 = 1'b0; slice_tready_1 = 1'b1;
    slice_result_tvalid_1 = 1'b0; slice_out_max_1 = '0; slice_index_1 = '0;
    m_axis_tready_1 = 1'b0;
    test_reset();
    test_peaks();
    test_back_to_back_stall();
    test_correlate_gating();
    test_reset_mid();
    test_random();
    test_foas1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/caf_controller.md
# caf_controller

Parametrised control and reduction core for the cross-ambiguity function (CAF) engine. It loads one frequency step into each of `foas` external `caf_slice` instances and gates the shared sample stream into those slices. It then scans the per-slice correlation peaks sequentially and returns the global peak magnitude, time index and frequency-offset index on an AXI-Stream-style output. It adds synchronous reset, the completed FIND_MAX/RETURN_MAX phases, and a flattened slice-result bus so any `foas` count is supported.

## Interface
- `phase_bits`, 10, width of a frequency step word
- `foas`, 3, number of frequency-offset slices (≥1)
- `foas_counter_bits`, 2, width of a slice index; 2^foas_counter_bits ≥ foas
- `length_counter_bits`, 3, width of a slice time index
- `out_max_bits`, 64, width of a slice peak magnitude (unsigned)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_axis_freq_step_tvalid`  in  1  frequency step offered
- `freq_step`  in  phase_bits  frequency step word
- `neg_shift`  in  1  step is a negative shift
- `s_axis_freq_step_tready`  out  1  step accepted when high with tvalid
- `slice_freq_step`  out  phase_bits  registered step broadcast to slices
- `slice_freq_step_valid`  out  foas  one-hot, one-cycle load strobe
- `slice_neg_shift`  out  foas  one-hot neg-shift flag, aligned with strobe
- `s_axis_tvalid`  in  1  sample (xi/xq/yi/yq, routed externally) valid
- `s_axis_tready`  out  1  samples accepted
- `slice_sample_tvalid`  out  1  broadcast sample strobe to slices
- `slice_tready`  in  foas  per-slice sample ready
- `slice_result_tvalid`  in  foas  per-slice peak valid
- `slice_out_max`  in  foas*out_max_bits  slice k at bits [k*out_max_bits +: out_max_bits]
- `slice_index`  in  foas*length_counter_bits  slice k time index, same packing
- `slice_result_tready`  out  foas  release strobe to slices
- `m_axis_tvalid`  out  1  global result valid
- `m_axis_tready`  in  1  downstream ready
- `out_max`  out  out_max_bits  global peak magnitude
- `index`  out  length_counter_bits  time index of peak
- `freq_step_index`  out  foas_counter_bits  slice index of peak
- `busy`  out  1  state ≠ LOAD

## Operation
- States: LOAD → CORRELATE → FIND_MAX → RETURN_MAX → LOAD. Reset state is LOAD, with load counter k=0.
- LOAD:
  - `s_axis_freq_step_tready`=1.
  - On each accept: `slice_freq_step`←`freq_step`; strobe bit k and `slice_neg_shift` bit k (=`neg_shift`) are high the next cycle only; k increments.
  - The foas-th accept sets k←0 and moves to CORRELATE.
- CORRELATE:
  - `s_axis_tready` = &`slice_tready` (combinational, state-qualified).
  - `slice_sample_tvalid` = `s_axis_tvalid` & `s_axis_tready`.
  - When &`slice_result_tvalid`=1, move to FIND_MAX with scan index j=0.
- FIND_MAX: lasts exactly foas cycles, one slice per cycle.
  - On j=0, load best←{slice 0 max, index, 0}.
  - On j>0, replace best only if `slice_out_max[j]` > best (unsigned, strict), so ties keep the lowest slice index.
  - After j=foas-1, move to RETURN_MAX.
- RETURN_MAX:
  - `m_axis_tvalid`=1; `out_max`/`index`/`freq_step_index` hold best and are stable while stalled.
  - On `m_axis_tready`: `slice_result_tready`=all-ones that same cycle (combinational), then LOAD.
- Inputs outside their state are ignored; the corresponding tready is 0.

## Timing
- Reset values: every output is 0, including the comb readies (gated by `rst`). best and k are cleared. `rst` in any state returns to LOAD next cycle with no further strobes.
- Step accept at edge N → load strobe high in cycle N+1 → the final accept's edge enters CORRELATE.
- &`slice_result_tvalid` sampled at edge M → `m_axis_tvalid` first high in cycle M+1+foas.
- foas=1: FIND_MAX is one cycle.
- Slices must hold result valid/data until `slice_result_tready`. A drop during FIND_MAX is a protocol violation and the outcome is undefined.
- k wraps to 0 only via the LOAD→CORRELATE transition. The step counter never overruns foas-1.

## Test plan
- Reset then 3 steps (0x010, 0x020 neg, 0x030) back-to-back → strobes 001, 010, 100 on consecutive cycles; `slice_neg_shift`=010 with 2nd strobe; state CORRELATE after 3rd accept.
- Slice peaks {5, 9, 7}, indices {1, 4, 2} → `out_max`=9, `index`=4, `freq_step_index`=1; `m_axis_tvalid` exactly foas+1 cycles after all-valid.
- Ties {8, 8, 3} → `freq_step_index`=0; peaks {0, 0, 0} → 0/slice-0 index.
- `m_axis_tready` low 10 cycles → outputs stable, no `slice_result_tready`; on accept, all-ones pulse for one cycle, then `s_axis_freq_step_tready`=1 next cycle.
- `slice_tready`=110 during CORRELATE → `s_axis_tready`=0, no `slice_sample_tvalid`; `freq_step` offered in CORRELATE → ignored.
- `rst` asserted mid-FIND_MAX and mid-LOAD (after 1 step) → next cycle LOAD, k=0, all outputs 0; foas=1 build repeats the peak test.
